// File: rtl/wide_mult_seq_pkg.sv
// ============================================================================
// Module : wide_mult_seq_pkg
// Brief  : Shared types and step tables for the wide sequential multiplier.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package wide_mult_seq_pkg;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam int STEP_W = 2;
  typedef logic [STEP_W-1:0] step_t;

  // Bit 0 selects the high half of a, bit 1 the high half of b.
  localparam step_t STEP_LL = 2'd0;
  localparam step_t STEP_HL = 2'd1;
  localparam step_t STEP_LH = 2'd2;
  localparam step_t STEP_HH = 2'd3;

  function automatic int unsigned step_shift_units(input step_t s);
    case (s)
      STEP_LL:          return 0;
      STEP_HL, STEP_LH: return 1;
      default:          return 2;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/wide_mult_seq_multiplier.sv
// ============================================================================
// Module : multiplier
// Brief  : Purely combinational N x N unsigned array multiplier.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multiplier #(
  parameter int N = 4
) (
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  output logic [2*N-1:0] o_p
);

  assign o_p = {{N{1'b0}}, i_a} * {{N{1'b0}}, i_b};

endmodule

`default_nettype wire

// File: rtl/wide_mult_seq.sv
// ============================================================================
// Module : wide_mult_seq
// Brief  : 2N x 2N unsigned multiply by time-sharing one N x N multiplier.
//          Define WIDE_MULT_SEQ_SKIP_EN to skip steps with a zero half-operand.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wide_mult_seq
  import wide_mult_seq_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] a,
  input  logic [2*N-1:0] b,
  output logic           busy,
  output logic           done,
  output logic [4*N-1:0] p
);

  state_t         r_state;
  step_t          r_step;
  logic [2*N-1:0] r_a;
  logic [2*N-1:0] r_b;
  logic [4*N-1:0] r_acc;
  logic [4*N-1:0] r_p;
  logic           r_busy;
  logic           r_done;

  logic [N-1:0]   w_a_half;
  logic [N-1:0]   w_b_half;
  logic [2*N-1:0] w_prod;
  logic [4*N-1:0] w_term;
  logic [4*N-1:0] w_sum;
  step_t          w_first;
  step_t          w_next;
  logic           w_last;
  logic           w_term_en;

  assign w_a_half = r_step[0] ? r_a[2*N-1:N] : r_a[N-1:0];
  assign w_b_half = r_step[1] ? r_b[2*N-1:N] : r_b[N-1:0];

  multiplier #(.N(N)) u_mult (
    .i_a (w_a_half),
    .i_b (w_b_half),
    .o_p (w_prod)
  );

  always_comb begin
    w_term = {{(2*N){1'b0}}, w_prod} << (step_shift_units(r_step) * N);
  end

  assign w_sum = r_acc + (w_term_en ? w_term : '0);

`ifdef WIDE_MULT_SEQ_SKIP_EN
  logic [3:0] r_mask;
  logic [3:0] w_mask_in;

  // A step contributes only when both of its half-operands are non-zero.
  always_comb begin
    w_mask_in[STEP_LL] = (|a[N-1:0])   && (|b[N-1:0]);
    w_mask_in[STEP_HL] = (|a[2*N-1:N]) && (|b[N-1:0]);
    w_mask_in[STEP_LH] = (|a[N-1:0])   && (|b[2*N-1:N]);
    w_mask_in[STEP_HH] = (|a[2*N-1:N]) && (|b[2*N-1:N]);
    w_first = STEP_LL;
    for (int i = 3; i >= 0; i--) begin
      if (w_mask_in[i]) w_first = step_t'(i);
    end
    w_next = r_step;
    w_last = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      if ((i > int'(r_step)) && r_mask[i]) begin
        w_next = step_t'(i);
        w_last = 1'b0;
      end
    end
    w_term_en = r_mask[r_step];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mask <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_mask <= w_mask_in;
    end
  end
`else
  assign w_first   = STEP_LL;
  assign w_next    = step_t'(r_step + 1'b1);
  assign w_last    = (r_step == STEP_HH);
  assign w_term_en = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_step  <= STEP_LL;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_p     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_acc   <= '0;
            r_step  <= w_first;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc <= w_sum;
          if (w_last) begin
            r_p     <= w_sum;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_step  <= STEP_LL;
            r_state <= S_IDLE;
          end else begin
            r_step <= w_next;
          end
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign p    = r_p;

endmodule

`default_nettype wire

// File: tb/tb_wide_mult_seq.sv
// ============================================================================
// Module : tb_wide_mult_seq
// Brief  : Randomised scoreboard bench for wide_mult_seq against an
//          arithmetic reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wide_mult_seq;

  localparam int N  = 4;
  localparam int W  = 2 * N;
  localparam int PW = 4 * N;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic [PW-1:0] p;

  always #5 clk = ~clk;

  wide_mult_seq #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  typedef struct {
    logic [W-1:0]  opa;
    logic [W-1:0]  opb;
    logic [PW-1:0] prod;
    int            done_cyc;
  } exp_t;

  exp_t          q[$];
  int            cyc      = 0;
  int            busy_end = 0;
  logic [PW-1:0] p_hold   = '0;
  bit            mon_en   = 1'b0;
  int            checks   = 0;
  int            errors   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ref_latency(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef WIDE_MULT_SEQ_SKIP_EN
    int n;
    n = 0;
    if (x[N-1:0] != 0 && y[N-1:0] != 0) n++;
    if (x[W-1:N] != 0 && y[N-1:0] != 0) n++;
    if (x[N-1:0] != 0 && y[W-1:N] != 0) n++;
    if (x[W-1:N] != 0 && y[W-1:N] != 0) n++;
    return (n == 0) ? 1 : n;
`else
    return 4;
`endif
  endfunction

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: compares busy/done/p every cycle against the model state.
  always @(negedge clk) begin : mon
    logic exp_busy;
    logic exp_done;
    exp_t e;
    if (mon_en) begin
      exp_busy = (cyc < busy_end);
      exp_done = (q.size() > 0) && (q[0].done_cyc == cyc);
      chk("busy", PW'(busy), PW'(exp_busy));
      chk("done", PW'(done), PW'(exp_done));
      if (exp_done) begin
        e = q.pop_front();
        p_hold = e.prod;
      end
      chk("p", p, p_hold);
    end
  end

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib);
    logic [PW-1:0] pr;
    int c0;
    while (cyc < busy_end) begin
      @(posedge clk);
      #1;
    end
    start = 1'b1;
    a = ia;
    b = ib;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    c0 = cyc;
    pr = PW'(ia) * PW'(ib);
    busy_end = c0 + ref_latency(ia, ib);
    q.push_back('{ia, ib, pr, busy_end});
  endtask

  task automatic poke(input logic [W-1:0] ia, input logic [W-1:0] ib);
    start = 1'b1;
    a = ia;
    b = ib;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] v;
    v = W'($urandom);
    if ($urandom_range(0, 3) == 0) v[N-1:0] = '0;
    if ($urandom_range(0, 3) == 0) v[W-1:N] = '0;
    return v;
  endfunction

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    idle(3);
    rst = 1'b0;
    mon_en = 1'b1;
    idle(2);

    issue(8'h12, 8'h34);
    issue(8'hFF, 8'hFF);
    issue(8'h80, 8'h02);

    issue(8'h9C, 8'h3D);
    idle(2);
    poke(8'h11, 8'h22);

    // Abort while step 2 is executing.
    issue(8'hC7, 8'hE5);
    idle(2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    busy_end = cyc;
    p_hold = '0;
    idle(2);

    issue(8'h0A, 8'h0B);
    issue(8'h00, 8'hAB);
    issue(8'h05, 8'h07);
    issue(8'h50, 8'h07);
    issue(8'h55, 8'h77);

    for (int i = 0; i < 200; i++) begin
      issue(rnd_op(), rnd_op());
      if ($urandom_range(0, 4) == 0) begin
        idle(1);
        if (cyc < busy_end) poke(W'($urandom), W'($urandom));
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 6));
    end

    for (int t = 0; t < 20 && q.size() > 0; t++) idle(1);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending results expected 0", q.size());
    end
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/wide_mult_seq.md
# wide_mult_seq

Sequential controller that computes a 2N×2N unsigned product by time-sharing a single N×N combinational `multiplier` over up to four partial-product steps. Operands are captured on a start strobe, the four half-by-half products are shifted and accumulated over successive cycles, and the result is presented with a one-cycle `done` pulse. It lets wide multiplications reuse the existing narrow array multiplier instead of instantiating a 2N-wide array.

## Interface
- `N`, default 4: half-operand width; the core multiplier is N×N and the operands are 2N bits wide.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  request; sampled only in IDLE.
- `a`  input  2N  multiplicand; captured when `start` is accepted.
- `b`  input  2N  multiplier; captured when `start` is accepted.
- `busy`  output  1  high while a product is in progress.
- `done`  output  1  one-cycle pulse; `p` is valid from this cycle onward.
- `p`  output  4N  registered product; held until the next completion.

## Operation
- State machine: IDLE and RUN.
- IDLE, `start`=1: latch `a` and `b`, clear the accumulator, set step=0, and go to RUN.
- IDLE, `start`=0: stay in IDLE.
- RUN executes steps 0..3, one per cycle, in this order:
  - step 0: aL·bL, shift 0.
  - step 1: aH·bL, shift N.
  - step 2: aL·bH, shift N.
  - step 3: aH·bH, shift 2N.
- aL/aH are the low/high N bits of the latched `a`; bL/bH are the same for `b`.
- Each step multiplexes the half-operands into the single core multiplier. The 2N-bit product is zero-extended to 4N bits, shifted, and added into a 4N-bit accumulator. The sum never overflows 4N bits, so no carry-out is needed.
- Final step: `p` ← accumulator + final term, `done` ← 1, `busy` ← 0, and the FSM returns to IDLE.
- `start` while RUN is ignored; there is no queueing.
- `start` in the cycle `done` is high is accepted, because the FSM is already in IDLE.
- Operands are unsigned. `a` and `b` may change freely after acceptance.
- Reset values: `busy`=0, `done`=0, `p`=0, accumulator=0, step=0, state=IDLE.
- Reset during RUN aborts the operation and clears `p`; no `done` is issued.

## Timing
- E0 is the clock edge where `start` is sampled high in IDLE. `busy` is 1 after E0.
- Accumulation happens at E1, E2, E3 and E4 (default build).
- After E4: `p` is valid, `done`=1 for exactly one cycle, and `busy`=0.
- Latency is 4 cycles from acceptance to `done`. Throughput is one product per 4 cycles (start re-asserted back-to-back on `done`).
- `done` is registered and never high on two consecutive cycles.
- The core multiplier is purely combinational inside one cycle, so the critical path is mux → N×N array → 4N adder.

## Configuration
- `WIDE_MULT_SEQ_SKIP_EN` defined:
  - On acceptance, build a 4-bit step mask: a step is needed only if both of its half-operands are non-zero.
  - RUN visits only the masked steps, in ascending order, one cycle each.
  - If the mask is empty, RUN lasts one cycle and produces `p`=0.
  - Latency = max(1, popcount(mask)) cycles.
- Macro undefined: fixed 4-step sequence, no mask logic.
- Both builds produce identical `p` values.

## Structure
- Shared package `wide_mult_seq_pkg`:
  - state encoding (IDLE, RUN);
  - step index width (2 bits);
  - step constants STEP_LL, STEP_HL, STEP_LH, STEP_HH;
  - shift-amount table per step, expressed in units of N.
- One sub-module: the existing `multiplier` with `.N(N)`, instantiated exactly once.
- Operand muxing, shift, accumulator, step counter and FSM stay in `wide_mult_seq`. Expected RTL size is about 150–250 lines.

## Test plan
- N=4, `a`=8'h12, `b`=8'h34, single `start` → `done` 4 cycles after acceptance, `p`=16'h03A8, `busy` high for exactly 4 cycles.
- `a`=8'hFF, `b`=8'hFF → `p`=16'hFE01; followed by back-to-back `start` with `a`=8'h80, `b`=8'h02 accepted on the `done` cycle → next `p`=16'h0100, 4 cycles later.
- `start` pulsed again 2 cycles into RUN with different operands → ignored; `p` equals the first operands' product; only one `done`.
- Assert `rst` during step 2 → next cycle `busy`=0, `p`=0, no `done`; a fresh `start` with `a`=8'h0A, `b`=8'h0B then yields `p`=16'h006E.
- `a`=8'h00, `b`=8'hAB → `p`=0.
  - Default build: latency 4.
  - With `WIDE_MULT_SEQ_SKIP_EN`: latency 1.
- With `WIDE_MULT_SEQ_SKIP_EN`:
  - `a`=8'h05, `b`=8'h07 → `p`=16'h0023, latency 1.
  - `a`=8'h50, `b`=8'h07 → `p`=16'h0230, latency 1.
  - `a`=8'h55, `b`=8'h77 → `p`=16'h2783, latency 4.
